rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Control FSM for the RV32I multi-cycle core. It sequences fetch, decode, execute, memory and write-back over the shared datapath: PC, IR, register file, immediate generator, ALU, and a single memory port. It classifies the latched opcode, drives the datapath select and write-enable strobes, and handles the memory request/ready handshake. It also counts retired instructions.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0] of the latched instruction
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  branch comparator result, valid in EXEC
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  store request, qualified by mem_req
- addr_sel  out  1  0 = PC, 1 = ALU result as memory address
- ir_we  out  1  latch IR and old_pc
- pc_we  out  1  write PC
- pc_src  out  1  0 = PC+4, 1 = ALU result
- alu_a_sel  out  2  0 = rs1, 1 = old_pc, 2 = zero
- alu_b_sel  out  1  0 = rs2, 1 = imm
- alu_op  out  2  0 = add, 1 = funct-decoded, 2 = compare
- rf_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = old_pc+4
- instret  out  CNT_W  retired-instruction count
- state_o  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- trap  out  1  illegal instruction trap; exists only with RV_CTRL_TRAP_EN

## Operation
- Opcode classes:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011, LOAD 0000011, STORE 0100011
  - OPIMM 0010011, OP 0110011
  - Every other value is illegal.
- FETCH: mem_req=1, addr_sel=0. Wait while mem_ready=0. When mem_ready=1: ir_we=1, pc_we=1, pc_src=0, go to DECODE.
- DECODE: one cycle, no strobes. A legal opcode goes to EXEC. An illegal opcode goes to TRAP or retires (see Configuration).
- EXEC operand selection:
  - OP: a=rs1, b=rs2, alu_op=1.
  - OPIMM: a=rs1, b=imm, alu_op=1.
  - LOAD/STORE/JALR: a=rs1, b=imm, alu_op=0.
  - LUI: a=zero, b=imm, alu_op=0.
  - AUIPC/JAL/BRANCH: a=old_pc, b=imm, alu_op=0.
- EXEC next state:
  - OP, OPIMM, LUI, AUIPC go to WB.
  - LOAD and STORE go to MEM.
  - JAL and JALR assert pc_we=1, pc_src=1, then go to WB.
  - BRANCH asserts pc_we=branch_taken, pc_src=1, then goes to FETCH (retire).
- MEM: mem_req=1, addr_sel=1, mem_we=(STORE). Wait while mem_ready=0. On mem_ready, STORE goes to FETCH (retire) and LOAD goes to WB.
- WB: rf_we=1. wb_sel is 1 for LOAD, 2 for JAL/JALR, 0 otherwise. Then go to FETCH (retire).
- Retire: instret increments by 1 in the same cycle as the retiring transition. It wraps modulo 2^CNT_W.
- Outputs are decoded from the state register and the opcode. Strobes not listed for a state are 0.

## Timing
- Reset: state=FETCH, instret=0, trap=0. While rst=1, all strobes are forced to 0, including mem_req.
- Reset mid-request: mem_req drops in the same cycle. After reset, the FSM starts a fresh fetch from the PC held by the datapath.
- Minimum cycles per instruction, with mem_ready=1 on the first request cycle:
  - BRANCH: 3
  - OP, OPIMM, LUI, AUIPC, JAL, JALR: 4
  - STORE: 4
  - LOAD: 5
  - Each mem_ready=0 cycle adds one cycle.
- During wait cycles, mem_req, mem_we and addr_sel are held stable. A mem_ready seen while mem_req=0 is ignored.
- pc_we in EXEC and rf_we in WB are each single-cycle pulses.

## Configuration
- RV_CTRL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP is absorbing: all strobes 0, trap=1, instret frozen. Only rst exits it.
- RV_CTRL_TRAP_EN undefined:
  - An illegal opcode retires as a NOP: DECODE goes to FETCH and instret increments.
  - The TRAP state and the trap port do not exist.

## Test plan
- ADDI (opcode 0010011), mem_ready tied 1:
  - states 0,1,2,4,0
  - alu_b_sel=1 in EXEC, rf_we=1 with wb_sel=0 in WB
  - instret 0→1 after 4 cycles
- LW with mem_ready low for 3 cycles in MEM:
  - mem_req, addr_sel=1, mem_we=0 held for 4 cycles
  - then WB with wb_sel=1; 8 cycles total
- BEQ with branch_taken=1, then BNE with branch_taken=0:
  - pc_we=1 then 0 in EXEC, pc_src=1
  - each back in FETCH after 3 cycles; instret +2
- JAL: pc_we=1, pc_src=1, alu_a_sel=1 in EXEC; rf_we=1, wb_sel=2 in WB.
- rst pulsed during a stalled SW in MEM:
  - next cycle state=0, mem_req=0, instret=0
  - no rf_we or pc_we before the next fetch completes
- Opcode 1110011:
  - with RV_CTRL_TRAP_EN: state=5, trap=1, instret unchanged over 10 cycles
  - without it: returns to FETCH, instret +1

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing and retired-instruction count.
// Optional illegal-instruction trap state enabled by defining RV_CTRL_TRAP_EN.
module rv_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [CNT_W-1:0] instret,
`ifdef RV_CTRL_TRAP_EN
    output logic             trap,
`endif
    output logic [2:0]       state_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
`ifdef RV_CTRL_TRAP_EN
        , StTrap = 3'd5
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic legal;

    assign is_lui    = (opcode == OpLui);
    assign is_auipc  = (opcode == OpAuipc);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign is_branch = (opcode == OpBranch);
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_opimm  = (opcode == OpOpImm);
    assign is_op     = (opcode == OpOp);
    assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                       is_opimm | is_op;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
`ifdef RV_CTRL_TRAP_EN
                    state_d = StTrap;
`else
                    state_d = StFetch;
                    retire  = 1'b1;
`endif
                end
            end
            StExec: begin
                if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_branch || !legal) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = is_store ? StFetch : StWb;
                    retire  = is_store;
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
`ifdef RV_CTRL_TRAP_EN
            StTrap: state_d = StTrap;
`endif
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= retire ? instret_q + CNT_W'(1) : instret_q;
        end
    end

    // Strobes are combinational on state/opcode so reset can kill a request in the same cycle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        alu_op    = 2'd0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                StExec: begin
                    if (is_lui) begin
                        alu_a_sel = 2'd2;
                    end else if (is_auipc || is_jal || is_branch) begin
                        alu_a_sel = 2'd1;
                    end
                    alu_b_sel = !is_op;
                    alu_op    = (is_op || is_opimm) ? 2'd1 : 2'd0;
                    if (is_jal || is_jalr) begin
                        pc_we  = 1'b1;
                        pc_src = 1'b1;
                    end else if (is_branch) begin
                        pc_we  = branch_taken;
                        pc_src = 1'b1;
                    end
                end
                StMem: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = is_store;
                end
                StWb: begin
                    rf_we = 1'b1;
                    if (is_load) begin
                        wb_sel = 2'd1;
                    end else if (is_jal || is_jalr) begin
                        wb_sel = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instret = instret_q;
    assign state_o = state_q;
`ifdef RV_CTRL_TRAP_EN
    assign trap    = !rst && (state_q == StTrap);
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomised bench for rv_multicycle_ctrl: per-instruction cycle traces built from the ISA
// class rules are played against the DUT and every cycle is compared.
module tb_rv_multicycle_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          mem_ready, branch_taken;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_b_sel, rf_we;
    logic [1:0]    alu_a_sel, alu_op, wb_sel;
    logic [CW-1:0] instret;
    logic [2:0]    state_o;
    logic          trap_w;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .instret(instret),
`ifdef RV_CTRL_TRAP_EN
        .trap(trap_w),
`endif
        .state_o(state_o)
    );
`ifndef RV_CTRL_TRAP_EN
    assign trap_w = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
        logic [1:0] a_sel;
        logic       b_sel;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       trap;
    } outs_t;

    typedef struct {
        outs_t o;
        logic  mr, bt, chk_state, retire;
    } cyc_t;

    cyc_t          tr[$];
    outs_t         exp_o;
    logic [CW-1:0] exp_i;
    logic          chk_state, chk;
    logic [CW-1:0] instret_m;
    logic          pend;
    int            checks = 0, passes = 0;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011;
    localparam logic [6:0] SYS = 7'b1110011;
    logic [6:0] legal_ops[9] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP};

    function automatic outs_t z(input logic [2:0] st);
        outs_t o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic cyc_t mk(input outs_t o, input logic mr, input logic rt);
        cyc_t c;
        c.o = o; c.mr = mr; c.bt = 1'($urandom); c.chk_state = 1'b1; c.retire = rt;
        return c;
    endfunction

    // Build the whole cycle-by-cycle trace of one instruction from its class.
    task automatic build(input logic [6:0] op, input int fst, input int mst, input logic bt);
        outs_t o;
        cyc_t  c;
        logic  legal;
        legal = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
        tr = {};
        for (int i = 0; i < fst; i++) begin
            o = z(0); o.mem_req = 1; tr.push_back(mk(o, 0, 0));
        end
        o = z(0); o.mem_req = 1; o.ir_we = 1; o.pc_we = 1; tr.push_back(mk(o, 1, 0));
        if (!legal) begin
`ifdef RV_CTRL_TRAP_EN
            tr.push_back(mk(z(1), 1'($urandom), 0));
            for (int i = 0; i < 10; i++) begin
                o = z(5); o.trap = 1; tr.push_back(mk(o, 1'($urandom), 0));
            end
`else
            tr.push_back(mk(z(1), 1'($urandom), 1));
`endif
            return;
        end
        tr.push_back(mk(z(1), 1'($urandom), 0));
        o = z(2);
        o.a_sel  = (op == LUI) ? 2'd2 : (op == AUIPC || op == JAL || op == BR) ? 2'd1 : 2'd0;
        o.b_sel  = (op != OP);
        o.alu_op = (op == OP || op == OPI) ? 2'd1 : 2'd0;
        o.pc_src = (op == JAL || op == JALR || op == BR);
        o.pc_we  = (op == JAL || op == JALR) || (op == BR && bt);
        c = mk(o, 1'($urandom), op == BR);
        c.bt = bt;
        tr.push_back(c);
        if (op == BR) return;
        if (op == LD || op == ST) begin
            o = z(3); o.mem_req = 1; o.addr_sel = 1; o.mem_we = (op == ST);
            for (int i = 0; i < mst; i++) tr.push_back(mk(o, 0, 0));
            tr.push_back(mk(o, 1, op == ST));
            if (op == ST) return;
        end
        o = z(4); o.rf_we = 1;
        o.wb_sel = (op == LD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0;
        tr.push_back(mk(o, 1'($urandom), 1));
    endtask

    task automatic play(input logic [6:0] op, input cyc_t c);
        @(posedge clk);
        #1;
        if (pend) instret_m = instret_m + 1'b1;
        pend         = c.retire;
        rst          = 1'b0;
        opcode       = op;
        mem_ready    = c.mr;
        branch_taken = c.bt;
        exp_o        = c.o;
        exp_i        = instret_m;
        chk_state    = c.chk_state;
        chk          = 1'b1;
    endtask

    // Plays the trace; rst_at >= 0 replaces that cycle with a reset pulse.
    task automatic run(input logic [6:0] op, input int fst, input int mst, input logic bt,
                       input int rst_at);
        build(op, fst, mst, bt);
        foreach (tr[i]) begin
            if (i == rst_at) begin
                do_reset();
                return;
            end
            play(op, tr[i]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        if (pend) instret_m = instret_m + 1'b1;
        pend      = 1'b0;
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        exp_o     = z(0);
        exp_i     = instret_m;
        chk_state = 1'b0;
        chk       = 1'b1;
        @(negedge clk);
        #1;
        instret_m = '0;
    endtask

    // One stalled fetch cycle used to pin absolute counter values.
    task automatic pin_dut(input string name, input logic [CW-1:0] want);
        @(posedge clk);
        #1;
        chk = 1'b0;
        if (pend) instret_m = instret_m + 1'b1;
        pend      = 1'b0;
        rst       = 1'b0;
        mem_ready = 1'b0;
        checks++;
        if (instret === want && state_o === 3'd0) passes++;
        else $display("FAIL %s: instret=%0d state=%0d, required instret=%0d state=0",
                      name, instret, state_o, want);
    endtask

    task automatic pin_model(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: model gave %0d, required %0d", name, got, want);
    endtask

    always @(negedge clk) begin
        if (chk) begin
            outs_t d;
            d = '{state_o, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_a_sel,
                  alu_b_sel, alu_op, rf_we, wb_sel, trap_w};
            if (!chk_state) d.state = exp_o.state;
            checks++;
            if (d === exp_o && instret === exp_i) passes++;
            else $display("FAIL cycle @%0t op=%b: outs=%h instret=%0d, required outs=%h instret=%0d",
                          $time, opcode, d, instret, exp_o, exp_i);
        end
    end

    initial begin
        int st_list;
        logic [6:0] op;
        rst = 1'b1; opcode = OPI; mem_ready = 1'b0; branch_taken = 1'b0;
        chk = 1'b0; chk_state = 1'b1; pend = 1'b0; instret_m = '0;
        exp_o = '0; exp_i = '0;
        repeat (3) @(posedge clk);

        build(OPI, 0, 0, 0);
        st_list = 0;
        foreach (tr[i]) st_list = st_list * 10 + int'(tr[i].o.state);
        pin_model("addi_states", st_list, 124);
        run(OPI, 0, 0, 0, -1);
        pin_dut("addi_instret", 4'd1);
        build(LD, 0, 3, 0);
        pin_model("lw_len", tr.size(), 8);
        run(LD, 0, 3, 0, -1);
        build(BR, 0, 0, 1);
        pin_model("beq_len", tr.size(), 3);
        run(BR, 0, 0, 1, -1);
        run(BR, 0, 0, 0, -1);
        pin_dut("branch_instret", 4'd4);
        run(JAL, 0, 0, 0, -1);
        run(ST, 0, 5, 0, 5);
        pin_dut("reset_mid_sw", 4'd0);
        run(OPI, 2, 0, 0, -1);
`ifdef RV_CTRL_TRAP_EN
        run(SYS, 0, 0, 0, -1);
        do_reset();
`else
        run(SYS, 0, 0, 0, -1);
        pin_dut("illegal_nop", 4'd2);
`endif

        for (int n = 0; n < 300; n++) begin
            op = legal_ops[$urandom_range(0, 8)];
`ifndef RV_CTRL_TRAP_EN
            if ($urandom_range(0, 9) == 0) op = SYS;
`endif
            run(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), -1);
            if ($urandom_range(0, 39) == 0) do_reset();
        end
        @(posedge clk);
        #1;
        chk = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
